// File: rtl/memshare_config_pkg.sv
// Shared memShare configuration: default sizes, DRC flag indices, profiler
// FSM states and the history entry layout.
package memshare_config_pkg;

  localparam int RQST_NUM              = 8;
  localparam int PORT_NUM              = 4;
  localparam int MAX_ALLOC_SEQ_NUM     = 2;
  localparam int ARR_RQST_TRACK_DEPTH  = 4;
  localparam int READ_2SEQ_TRACK_DEPTH = 4;
  localparam int MEMSHARE_DRC_NUM      = 3;

  typedef enum logic [1:0] {
    DRC1_SPLIT     = 2'd0,
    DRC2_OVERLAP   = 2'd1,
    DRC3_B2B_SPLIT = 2'd2
  } memshare_drc_index;

  typedef enum logic {
    PROF_IDLE  = 1'b0,
    PROF_ISSUE = 1'b1
  } memshare_prof_state;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  typedef struct packed {
    logic                vld;
    logic                split;
    logic [RQST_NUM-1:0] pattern;
  } memshare_hist_entry;

endpackage

// File: rtl/memshare_lowbit_select.sv
// Picks the lowest-index N set bits of a mask and reports how many were picked.
module memshare_lowbit_select #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  mask,
  output logic [W-1:0]  sel,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] N_C = CW'(N);

  always_comb begin
    sel = '0;
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      if (mask[i] && (cnt < N_C)) begin
        sel[i] = 1'b1;
        cnt    = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/memshare_rqst_profiler.sv
// Arrival-requestor profiler: splits accepted request patterns into allocation
// sequences, tracks pattern history and raises the memShare DRC flags.
module memshare_rqst_profiler #(
  parameter int RQST_NUM              = memshare_config_pkg::RQST_NUM,
  parameter int PORT_NUM              = memshare_config_pkg::PORT_NUM,
  parameter int MAX_ALLOC_SEQ_NUM     = memshare_config_pkg::MAX_ALLOC_SEQ_NUM,
  parameter int TRACK_DEPTH           = memshare_config_pkg::ARR_RQST_TRACK_DEPTH,
  parameter int READ_2SEQ_TRACK_DEPTH = memshare_config_pkg::READ_2SEQ_TRACK_DEPTH,
  parameter int MEMSHARE_DRC_NUM      = memshare_config_pkg::MEMSHARE_DRC_NUM,
  localparam int SEQ_W = (MAX_ALLOC_SEQ_NUM > 1) ? $clog2(MAX_ALLOC_SEQ_NUM) : 1,
  localparam int OCC_W = $clog2(TRACK_DEPTH + 1)
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        rqst_vld,
  output logic                        rqst_rdy,
  input  logic [RQST_NUM-1:0]         rqst_pattern,
  input  logic                        hist_flush,
  output logic                        alloc_vld,
  input  logic                        alloc_rdy,
  output logic [RQST_NUM-1:0]         alloc_mask,
  output logic [SEQ_W-1:0]            alloc_seq_idx,
  output logic                        alloc_last,
  output logic [MEMSHARE_DRC_NUM-1:0] drc_flags,
  output logic                        drc_err,
  output logic [OCC_W-1:0]            hist_occupancy,
  output logic                        state_dbg
);

  import memshare_config_pkg::*;

  localparam int CNT_W = $clog2(RQST_NUM + 1);
  localparam int unsigned OVF_LIMIT = PORT_NUM * MAX_ALLOC_SEQ_NUM;
  localparam int unsigned SPLIT_LIMIT = PORT_NUM;

  if (READ_2SEQ_TRACK_DEPTH < 1 || READ_2SEQ_TRACK_DEPTH > TRACK_DEPTH ||
      MEMSHARE_DRC_NUM < 3) begin : g_param_err
    $error("memshare_rqst_profiler: illegal READ_2SEQ_TRACK_DEPTH or MEMSHARE_DRC_NUM");
  end

  typedef struct packed {
    logic                vld;
    logic                split;
    logic [RQST_NUM-1:0] pattern;
  } hist_t;

  hist_t                        hist_q [TRACK_DEPTH];
  logic [0:0]                   state;
  logic [RQST_NUM-1:0]          rem_mask, sel_mask;
  logic [CNT_W-1:0]             rem_pc, sel_pc, pat_pc;
  logic [SEQ_W-1:0]             seq_idx;
  logic [MEMSHARE_DRC_NUM-1:0]  flags_q, flags_new;
  logic [OCC_W-1:0]             occ_q;
  logic [31:0]                  pc_ext;
  logic accept, overflow, split, push, grant, last, drc2_hit, drc3_hit;

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; the alloc outputs are held unchanged while alloc_vld waits on alloc_rdy.
  assign rqst_rdy = (state == ST_IDLE);
  assign accept   = rqst_vld && rqst_rdy;
  assign pat_pc   = CNT_W'($countones(rqst_pattern));
  assign pc_ext   = 32'(pat_pc);
  assign overflow = pc_ext > OVF_LIMIT;
  assign split    = pc_ext > SPLIT_LIMIT;
  assign push     = accept && (pat_pc != '0) && !overflow;

  memshare_lowbit_select #(.W(RQST_NUM), .N(PORT_NUM), .CW(CNT_W)) u_lowbit (
    .mask (rem_mask),
    .sel  (sel_mask),
    .cnt  (sel_pc)
  );

  assign alloc_vld      = (state == ST_ISSUE);
  assign grant          = alloc_vld && alloc_rdy;
  assign last           = (rem_pc == sel_pc);
  assign alloc_mask     = alloc_vld ? sel_mask : '0;
  assign alloc_last     = alloc_vld && last;
  assign alloc_seq_idx  = seq_idx;
  assign drc_flags      = flags_q;
  assign hist_occupancy = occ_q;
  assign state_dbg      = state;

  // A flush in the same cycle as acceptance hides the old history from the check.
  always_comb begin
    drc2_hit = 1'b0;
    for (int i = 0; i < READ_2SEQ_TRACK_DEPTH; i++) begin
      if (hist_q[i].vld && !hist_flush && (|(hist_q[i].pattern & rqst_pattern)))
        drc2_hit = 1'b1;
    end
  end

  assign drc3_hit = hist_q[0].vld && hist_q[0].split && !hist_flush &&
                    (|(hist_q[0].pattern & rqst_pattern));

  always_comb begin
    flags_new                 = '0;
    flags_new[DRC1_SPLIT]     = split;
    flags_new[DRC2_OVERLAP]   = drc2_hit;
    flags_new[DRC3_B2B_SPLIT] = drc3_hit;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rem_mask <= '0;
      rem_pc   <= '0;
      seq_idx  <= '0;
      flags_q  <= '0;
      drc_err  <= 1'b0;
      occ_q    <= '0;
      for (int i = 0; i < TRACK_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      drc_err <= accept && overflow;

      if (push) begin
        hist_q[0] <= '{vld: 1'b1, split: split, pattern: rqst_pattern};
        for (int i = 1; i < TRACK_DEPTH; i++)
          hist_q[i] <= hist_flush ? '0 : hist_q[i-1];
        if (hist_flush)
          occ_q <= OCC_W'(1);
        else if (occ_q != OCC_W'(TRACK_DEPTH))
          occ_q <= occ_q + 1'b1;
      end else if (hist_flush) begin
        for (int i = 0; i < TRACK_DEPTH; i++) hist_q[i] <= '0;
        occ_q <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (push) begin
            state    <= ST_ISSUE;
            rem_mask <= rqst_pattern;
            rem_pc   <= pat_pc;
            seq_idx  <= '0;
            flags_q  <= flags_new;
          end
        end
        ST_ISSUE: begin
          if (grant) begin
            rem_mask <= rem_mask & ~sel_mask;
            rem_pc   <= rem_pc - sel_pc;
            seq_idx  <= seq_idx + 1'b1;
            if (last) begin
              state   <= ST_IDLE;
              seq_idx <= '0;
              flags_q <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memshare_rqst_profiler.sv
// Bench for memshare_rqst_profiler: directed plan plus random patterns against
// a queue-based history model; a second instance covers the overflow path.
module tb_memshare_rqst_profiler;

  localparam int PORT0 = 4;
  localparam int PORT1 = 2;
  localparam int MAXS  = 2;
  localparam int DEPTH = 4;
  localparam int READ  = 4;

  typedef struct {
    logic [7:0] pat;
    bit         split;
  } ent_t;

  logic       clk;
  logic       rst;

  logic       r0_vld, r0_rdy, f0, a0_vld, a0_rdy, a0_idx, a0_last, d0_err, st0;
  logic [7:0] r0_pat, a0_mask;
  logic [2:0] d0_flags, occ0;

  logic       r1_vld, r1_rdy, f1, a1_vld, a1_rdy, a1_idx, a1_last, d1_err, st1;
  logic [7:0] r1_pat, a1_mask;
  logic [2:0] d1_flags, occ1;

  int         n_assert;
  int         n_fail;
  ent_t       mh[$];
  logic [7:0] exp_q[$];
  logic [2:0] exp_flags;

  memshare_rqst_profiler u_dut0 (
    .sys_clk(clk), .rst(rst), .rqst_vld(r0_vld), .rqst_rdy(r0_rdy),
    .rqst_pattern(r0_pat), .hist_flush(f0), .alloc_vld(a0_vld), .alloc_rdy(a0_rdy),
    .alloc_mask(a0_mask), .alloc_seq_idx(a0_idx), .alloc_last(a0_last),
    .drc_flags(d0_flags), .drc_err(d0_err), .hist_occupancy(occ0), .state_dbg(st0)
  );

  memshare_rqst_profiler #(.PORT_NUM(PORT1)) u_dut1 (
    .sys_clk(clk), .rst(rst), .rqst_vld(r1_vld), .rqst_rdy(r1_rdy),
    .rqst_pattern(r1_pat), .hist_flush(f1), .alloc_vld(a1_vld), .alloc_rdy(a1_rdy),
    .alloc_mask(a1_mask), .alloc_seq_idx(a1_idx), .alloc_last(a1_last),
    .drc_flags(d1_flags), .drc_err(d1_err), .hist_occupancy(occ1), .state_dbg(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference split: repeatedly hand out the lowest `port` requestors still waiting.
  task automatic model_split(input logic [7:0] pat, input int port);
    logic [7:0] rem, m;
    int n;
    exp_q.delete();
    rem = pat;
    while (rem != 8'h00) begin
      m = 8'h00;
      n = 0;
      for (int i = 0; i < 8; i++) begin
        if (rem[i] && n < port) begin
          m[i] = 1'b1;
          n++;
        end
      end
      exp_q.push_back(m);
      rem = rem & ~m;
    end
  endtask

  // History model for the default instance: newest entry at the queue front.
  task automatic model_accept(input logic [7:0] pat, input bit flush);
    int  pc;
    bit  d1, d2, d3;
    ent_t e;
    if (flush) mh.delete();
    pc = $countones(pat);
    d1 = (pc > PORT0);
    d2 = 1'b0;
    for (int i = 0; i < mh.size() && i < READ; i++)
      if ((mh[i].pat & pat) != 8'h00) d2 = 1'b1;
    d3 = (mh.size() > 0) && mh[0].split && ((mh[0].pat & pat) != 8'h00);
    exp_flags = {d3, d2, d1};
    model_split(pat, PORT0);
    if (pc > 0 && pc <= PORT0 * MAXS) begin
      e.pat = pat;
      e.split = d1;
      mh.push_front(e);
      if (mh.size() > DEPTH) void'(mh.pop_back());
    end
  endtask

  task automatic chk_seq0(input string tag, input int s, input int nseq);
    chk({tag, "_vld"},   32'(a0_vld),   32'd1);
    chk({tag, "_mask"},  32'(a0_mask),  32'(exp_q[s]));
    chk({tag, "_idx"},   32'(a0_idx),   32'(s));
    chk({tag, "_last"},  32'(a0_last),  32'(s == nseq - 1));
    chk({tag, "_flags"}, 32'(d0_flags), 32'(exp_flags));
    chk({tag, "_rdy"},   32'(r0_rdy),   32'd0);
  endtask

  // Driver: present one pattern, then drain its sequences with random stalls.
  task automatic run0(input logic [7:0] pat, input bit flush, input int max_stall,
                      input int hand_flags);
    int stall, nseq;
    chk("idle_rdy", 32'(r0_rdy), 32'd1);
    r0_vld = 1'b1;
    r0_pat = pat;
    f0     = flush;
    model_accept(pat, flush);
    nseq = exp_q.size();
    @(negedge clk);
    r0_vld = 1'b0;
    r0_pat = 8'h00;
    f0     = 1'b0;
    chk("no_err", 32'(d0_err), 32'd0);
    if (nseq == 0) chk("zero_vld", 32'(a0_vld), 32'd0);
    if (nseq > 0 && hand_flags >= 0) chk("plan_flags", 32'(d0_flags), 32'(hand_flags));
    for (int s = 0; s < nseq; s++) begin
      stall = $urandom_range(0, max_stall);
      for (int c = 0; c <= stall; c++) begin
        a0_rdy = (c == stall);
        chk_seq0("seq", s, nseq);
        @(negedge clk);
      end
      a0_rdy = 1'b0;
    end
    chk("done_vld", 32'(a0_vld), 32'd0);
    chk("done_rdy", 32'(r0_rdy), 32'd1);
    chk("occupancy", 32'(occ0), 32'(mh.size()));
  endtask

  task automatic flush0();
    f0 = 1'b1;
    @(negedge clk);
    f0 = 1'b0;
    mh.delete();
    chk("flush_occ", 32'(occ0), 32'd0);
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_vld"},   32'(a0_vld),   32'd0);
    chk({tag, "_mask"},  32'(a0_mask),  32'd0);
    chk({tag, "_idx"},   32'(a0_idx),   32'd0);
    chk({tag, "_last"},  32'(a0_last),  32'd0);
    chk({tag, "_flags"}, 32'(d0_flags), 32'd0);
    chk({tag, "_err"},   32'(d0_err),   32'd0);
    chk({tag, "_occ"},   32'(occ0),     32'd0);
    chk({tag, "_rdy"},   32'(r0_rdy),   32'd1);
  endtask

  initial begin
    int nseq;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    r0_vld = 1'b0; r0_pat = 8'h00; f0 = 1'b0; a0_rdy = 1'b0;
    r1_vld = 1'b0; r1_pat = 8'h00; f1 = 1'b0; a1_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset0("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset0("post_reset");

    // Overflow on the narrow instance: 6 requestors exceed 2 ports x 2 sequences.
    r1_vld = 1'b1; r1_pat = 8'h3F;
    @(negedge clk);
    r1_vld = 1'b0;
    chk("ovf_err", 32'(d1_err), 32'd1);
    chk("ovf_vld", 32'(a1_vld), 32'd0);
    chk("ovf_occ", 32'(occ1), 32'd0);
    @(negedge clk);
    chk("ovf_err_pulse", 32'(d1_err), 32'd0);
    chk("ovf_vld2", 32'(a1_vld), 32'd0);
    chk("ovf_rdy", 32'(r1_rdy), 32'd1);

    // Exactly at the limit on the narrow instance: two sequences of two.
    model_split(8'h0F, PORT1);
    nseq = exp_q.size();
    r1_vld = 1'b1; r1_pat = 8'h0F;
    @(negedge clk);
    r1_vld = 1'b0;
    for (int s = 0; s < nseq; s++) begin
      a1_rdy = 1'b1;
      chk("p2_vld", 32'(a1_vld), 32'd1);
      chk("p2_mask", 32'(a1_mask), 32'(exp_q[s]));
      chk("p2_idx", 32'(a1_idx), 32'(s));
      chk("p2_last", 32'(a1_last), 32'(s == nseq - 1));
      chk("p2_drc1", 32'(d1_flags[0]), 32'd1);
      @(negedge clk);
    end
    a1_rdy = 1'b0;
    chk("p2_done", 32'(a1_vld), 32'd0);
    chk("p2_occ", 32'(occ1), 32'd1);

    // Directed plan on the default instance.
    run0(8'h05, 1'b0, 0, 3'b000);
    run0(8'hB7, 1'b0, 2, 3'b011);
    flush0();
    run0(8'h01, 1'b0, 1, 3'b000);
    run0(8'h02, 1'b0, 1, 3'b000);
    run0(8'h04, 1'b0, 1, 3'b000);
    run0(8'h08, 1'b0, 1, 3'b000);
    run0(8'h10, 1'b0, 1, 3'b000);
    run0(8'h01, 1'b0, 0, 3'b000);
    run0(8'h10, 1'b0, 0, 3'b010);
    run0(8'h00, 1'b0, 0, -1);
    run0(8'hF3, 1'b1, 1, 3'b001);
    run0(8'h01, 1'b0, 1, 3'b110);
    run0(8'hF3, 1'b0, 1, 3'b011);
    run0(8'h01, 1'b1, 1, 3'b000);
    chk("flush_accept_occ", 32'(occ0), 32'd1);

    // Random patterns with occasional flush and random backpressure.
    for (int k = 0; k < 40; k++)
      run0(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), 3, -1);

    // Stall seq0 of 7F for five cycles, then reset during seq1.
    flush0();
    r0_vld = 1'b1; r0_pat = 8'h7F;
    model_accept(8'h7F, 1'b0);
    nseq = exp_q.size();
    @(negedge clk);
    r0_vld = 1'b0; r0_pat = 8'h00;
    a0_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_seq0("stall", 0, nseq);
      @(negedge clk);
    end
    a0_rdy = 1'b1;
    chk_seq0("stall_rel", 0, nseq);
    @(negedge clk);
    a0_rdy = 1'b0;
    chk_seq0("seq1", 1, nseq);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mh.delete();
    chk_reset0("mid_reset");
    @(negedge clk);
    chk_reset0("after_reset");
    run0(8'h05, 1'b0, 0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
